// File: rtl/aq_sdram_writer.sv
// Acquisition writer: packs 24-bit antenna samples into 32-bit words,
// buffers them in a small FIFO and streams them to sequential MCB addresses.
module aq_sdram_writer #(
   parameter int ABITS  = 20,
   parameter int ASB    = ABITS - 2,
   parameter int FDEPTH = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          aq_ce_i,
   input  logic          ax_valid_i,
   input  logic [23:0]   ax_data_i,
   output logic          mcb_ce_o,
   output logic          mcb_wr_o,
   input  logic          mcb_rdy_i,
   output logic [ASB:0]  mcb_adr_o,
   output logic [31:0]   mcb_dat_o,
   output logic          aq_full_o,
   output logic          aq_ovf_o,
   output logic          aq_busy_o
);

   localparam int FAW = $clog2(FDEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FULL} state_t;

   state_t             state_q, state_d;
   logic [1:0]         phase_q;
   logic [23:0]        res_q;
   logic               pk_vld_q;
   logic [31:0]        pk_word_q;
   logic [31:0]        mem [FDEPTH];
   logic [FAW:0]       wptr_q, rptr_q;
   logic [ASB:0]       adr_q;
   logic               ovf_q;
   logic               start, take, active, empty, full;
   logic               ce, pop, push, push_ok, last_xfer;

   assign start   = (state_q == S_IDLE) && aq_ce_i;
   assign take    = (state_q == S_RUN) && ax_valid_i;
   assign active  = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign empty   = (wptr_q == rptr_q);
   // Extra pointer bit distinguishes full from empty across wrap-around
   assign full    = (wptr_q[FAW] != rptr_q[FAW]) &&
                    (wptr_q[FAW-1:0] == rptr_q[FAW-1:0]);
   // Packer output only lands in the FIFO while the writer is active;
   // words produced after the region fills are discarded silently
   assign push    = pk_vld_q && active;
   assign push_ok = push && (!full || pop);

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode and MCB request
   always_comb begin
      state_d   = state_q;
      ce        = active && !empty;
      pop       = ce && mcb_rdy_i;
      last_xfer = pop && (adr_q == '1);
      case (state_q)
         S_IDLE:  if (aq_ce_i) state_d = S_RUN;
         S_RUN: begin
            if (last_xfer)     state_d = S_FULL;
            else if (!aq_ce_i) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (last_xfer) state_d = S_FULL;
            else if (empty && !pk_vld_q && (phase_q == 2'd0)) state_d = S_IDLE;
         end
         S_FULL:  if (!aq_ce_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sample packer: residue is kept zero-extended so a flush is just {8'h0, res}
   always_ff @(posedge clk_i) begin
      if (rst_i || start) begin
         phase_q   <= 2'd0;
         res_q     <= '0;
         pk_vld_q  <= 1'b0;
         pk_word_q <= '0;
      end else begin
         pk_vld_q <= 1'b0;
         if (take) begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
               2'd0: res_q <= ax_data_i;
               2'd1: begin
                  pk_word_q <= {ax_data_i[7:0], res_q};
                  res_q     <= {8'h00, ax_data_i[23:8]};
                  pk_vld_q  <= 1'b1;
               end
               2'd2: begin
                  pk_word_q <= {ax_data_i[15:0], res_q[15:0]};
                  res_q     <= {16'h0000, ax_data_i[23:16]};
                  pk_vld_q  <= 1'b1;
               end
               default: begin
                  pk_word_q <= {ax_data_i, res_q[7:0]};
                  res_q     <= '0;
                  pk_vld_q  <= 1'b1;
               end
            endcase
         end else if ((state_q == S_DRAIN) && (phase_q != 2'd0)) begin
            pk_word_q <= {8'h00, res_q};
            pk_vld_q  <= 1'b1;
            phase_q   <= 2'd0;
            res_q     <= '0;
         end
      end
   end

   // FIFO pointers
   always_ff @(posedge clk_i) begin
      if (rst_i || start) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + {{FAW{1'b0}}, 1'b1};
         if (pop)     rptr_q <= rptr_q + {{FAW{1'b0}}, 1'b1};
      end
   end

   // FIFO storage; a push onto a full FIFO with a pop overwrites the slot being read out
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wptr_q[FAW-1:0]] <= pk_word_q;
   end

   // Write address and sticky overflow
   always_ff @(posedge clk_i) begin
      if (rst_i || start) begin
         adr_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (pop)                   adr_q <= adr_q + {{ASB{1'b0}}, 1'b1};
         if (push && full && !pop)  ovf_q <= 1'b1;
      end
   end

   assign mcb_ce_o  = ce;
   assign mcb_wr_o  = ce;
   assign mcb_adr_o = adr_q;
   assign mcb_dat_o = ce ? mem[rptr_q[FAW-1:0]] : 32'h0;
   assign aq_full_o = (state_q == S_FULL);
   assign aq_busy_o = (state_q != S_IDLE);
   assign aq_ovf_o  = ovf_q;

endmodule
